// File: rtl/uart_imem_loader_if.sv
// Boot-loader side signals: start/rx stimulus plus the imem write port and load status.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 14
);
    logic              start;
    logic              rx;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;
    logic [15:0]       word_count;

    modport master (
        output start, rx,
        input  imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, word_count
    );

    modport slave (
        input  start, rx,
        output imem_we, imem_addr, imem_wdata, cpu_hold, busy, done, err, word_count
    );
endinterface

// File: rtl/uart_imem_loader.sv
// UART boot loader: receives a framed program image, writes 32-bit words to imem,
// and holds the CPU in reset until a frame with a good checksum has landed.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | after reset, nothing armed
// WAIT_HDR | armed, discarding bytes until 0xA5
// LEN_L    | waiting for low byte of word count
// LEN_H    | waiting for high byte; range-checks LEN
// DATA     | assembling little-endian words, one imem write per word
// CSUM     | comparing the trailing byte with the data-byte sum
// DONE     | good image, CPU released
// ERR      | bad image, CPU still held
module uart_imem_loader #(
    parameter int CLKS_PER_BIT = 217,
    parameter int ADDR_W       = 14,
    parameter int MAX_WORDS    = 16384,
    parameter int TIMEOUT_BITS = 64
) (
    input logic               clk,
    input logic               rst,
    uart_imem_loader_if.slave bus
);
    localparam int BIT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W      = $clog2(TO_CYCLES + 1);
    localparam logic [BIT_W-1:0] FULL_BIT = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] HALF_BIT = BIT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TO_CYCLES - 1);
    localparam logic [16:0]      MAX_LEN  = 17'(MAX_WORDS);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_HDR, S_LEN_L, S_LEN_H, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    rx_state_t         rx_state, rx_state_next;
    logic              rx_s1, rx_s2, rx_prev;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
    logic [2:0]        bit_idx, bit_idx_next;
    logic [7:0]        shift, shift_next;
    logic              byte_valid, frame_err;

    state_t            state, state_next;
    logic [TO_W-1:0]   to_cnt;
    logic [7:0]        len_lo;
    logic [15:0]       len;
    logic [7:0]        sum;
    logic [1:0]        byte_pos;
    logic [23:0]       word_buf;
    logic [ADDR_W-1:0] index;
    logic              idle_like, load_go, in_frame, timed_out, last_word;

    logic              imem_we_q, cpu_hold_q, busy_q, done_q, err_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;
    logic [15:0]       word_count_q;

    // rx_prev lets a line that is already low (e.g. after a bad stop bit) not count as a start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= bus.rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= R_IDLE;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '0;
        end else begin
            rx_state <= rx_state_next;
            bit_cnt  <= bit_cnt_next;
            bit_idx  <= bit_idx_next;
            shift    <= shift_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state;
        bit_cnt_next  = bit_cnt;
        bit_idx_next  = bit_idx;
        shift_next    = shift;
        byte_valid    = 1'b0;
        frame_err     = 1'b0;
        case (rx_state)
            R_IDLE: begin
                if (rx_prev && !rx_s2) begin
                    rx_state_next = R_START;
                    bit_cnt_next  = HALF_BIT;
                end
            end
            R_START: begin
                if (bit_cnt == '0) begin
                    if (rx_s2) begin
                        rx_state_next = R_IDLE;
                    end else begin
                        rx_state_next = R_DATA;
                        bit_cnt_next  = FULL_BIT;
                        bit_idx_next  = 3'd0;
                    end
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            R_DATA: begin
                if (bit_cnt == '0) begin
                    shift_next   = {rx_s2, shift[7:1]};
                    bit_cnt_next = FULL_BIT;
                    bit_idx_next = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_state_next = R_STOP;
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            R_STOP: begin
                if (bit_cnt == '0) begin
                    rx_state_next = R_IDLE;
                    if (rx_s2) byte_valid = 1'b1;
                    else       frame_err  = 1'b1;
                end else begin
                    bit_cnt_next = bit_cnt - 1'b1;
                end
            end
            default: rx_state_next = R_IDLE;
        endcase
    end

    assign idle_like = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR);
    assign load_go   = bus.start && idle_like;
    assign in_frame  = (state == S_LEN_L) || (state == S_LEN_H) ||
                       (state == S_DATA)  || (state == S_CSUM);
    assign timed_out = in_frame && (to_cnt == '0) && !byte_valid;
    assign last_word = (byte_pos == 2'd3) && ((word_count_q + 16'd1) == len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) state_next = S_WAIT_HDR;
            end
            S_WAIT_HDR: begin
                if (byte_valid && shift == 8'hA5) state_next = S_LEN_L;
            end
            S_LEN_L: begin
                if (byte_valid) state_next = S_LEN_H;
            end
            S_LEN_H: begin
                if (byte_valid) begin
                    if ({shift, len_lo} == 16'd0 || {1'b0, shift, len_lo} > MAX_LEN)
                        state_next = S_ERR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (byte_valid && last_word) state_next = S_CSUM;
            end
            S_CSUM: begin
                if (byte_valid) state_next = (shift == sum) ? S_DONE : S_ERR;
            end
            default: state_next = S_IDLE;
        endcase
        if (in_frame && (frame_err || timed_out)) state_next = S_ERR;
    end

    // Status outputs are registered from state_next so they change together with state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            word_count_q <= '0;
            to_cnt       <= TO_LOAD;
            len_lo       <= '0;
            len          <= '0;
            sum          <= '0;
            byte_pos     <= '0;
            word_buf     <= '0;
            index        <= '0;
        end else begin
            imem_we_q  <= 1'b0;
            done_q     <= (state_next == S_DONE);
            err_q      <= (state_next == S_ERR);
            cpu_hold_q <= (state_next != S_IDLE) && (state_next != S_DONE);
            busy_q     <= (state_next != S_IDLE) && (state_next != S_DONE) &&
                          (state_next != S_ERR);

            if (!in_frame || byte_valid) to_cnt <= TO_LOAD;
            else if (to_cnt != '0)       to_cnt <= to_cnt - 1'b1;

            if (load_go) begin
                word_count_q <= '0;
                index        <= '0;
                sum          <= '0;
                byte_pos     <= '0;
            end else if (byte_valid) begin
                case (state)
                    S_LEN_L: len_lo <= shift;
                    S_LEN_H: len    <= {shift, len_lo};
                    S_DATA: begin
                        sum      <= sum + shift;
                        byte_pos <= byte_pos + 2'd1;
                        case (byte_pos)
                            2'd0: word_buf[7:0]   <= shift;
                            2'd1: word_buf[15:8]  <= shift;
                            2'd2: word_buf[23:16] <= shift;
                            default: begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= index;
                                imem_wdata_q <= {shift, word_buf};
                                index        <= index + ADDR_W'(1);
                                word_count_q <= word_count_q + 16'd1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign bus.cpu_hold   = cpu_hold_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.word_count = word_count_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Bench for uart_imem_loader: frame vectors from a table, imem writes checked
// against a queue of expected {addr, data}, plus hand-written corner sequences.
module tb_uart_imem_loader;
    localparam int CPB       = 16;
    localparam int ADDR_W    = 14;
    localparam int MAX_WORDS = 8;
    localparam int TO_BITS   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_imem_loader_if #(.ADDR_W(ADDR_W)) bus();

    uart_imem_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W(ADDR_W),
        .MAX_WORDS(MAX_WORDS),
        .TIMEOUT_BITS(TO_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [95:0] bytes;
        int          nb;
        logic [63:0] words;
        int          nw;
        bit          exp_done;
    } vec_t;

    int  checks   = 0;
    int  failures = 0;
    wr_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_word(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && bus.imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got addr %h data %h expected no write",
                         bus.imem_addr, bus.imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(bus.imem_addr), 32'(e.addr));
                check("write_data", bus.imem_wdata, e.data);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        @(negedge clk) bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = !bad_stop;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (bus.busy === 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        check("busy_drop", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_we"},    32'(bus.imem_we), 32'd0);
        check({tag, "_addr"},  32'(bus.imem_addr), 32'd0);
        check({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        check({tag, "_hold"},  32'(bus.cpu_hold), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
        check({tag, "_done"},  32'(bus.done), 32'd0);
        check({tag, "_err"},   32'(bus.err), 32'd0);
        check({tag, "_wc"},    32'(bus.word_count), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vecs[5];

    initial begin
        vec_t v;
        // Bytes are listed first-sent in the least significant position.
        vecs[0] = '{bytes: 96'hB6001000_93000000_130002A5, nb: 12,
                    words: {32'h00100093, 32'h00000013}, nw: 2, exp_done: 1'b1};
        vecs[1] = '{bytes: 96'hB7001000_93000000_130002A5, nb: 12,
                    words: {32'h00100093, 32'h00000013}, nw: 2, exp_done: 1'b0};
        vecs[2] = '{bytes: 96'h0000_38DEADBEEF0001A5FF00, nb: 10,
                    words: {32'h0, 32'hDEADBEEF}, nw: 1, exp_done: 1'b1};
        vecs[3] = '{bytes: 96'h0000A5, nb: 3, words: 64'h0, nw: 0, exp_done: 1'b0};
        vecs[4] = '{bytes: 96'h0009A5, nb: 3, words: 64'h0, nw: 0, exp_done: 1'b0};

        bus.start = 1'b0;
        bus.rx    = 1'b1;
        rst       = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        for (int k = 0; k < 5; k++) begin
            v = vecs[k];
            pulse_start();
            check("armed_busy", 32'(bus.busy), 32'd1);
            check("armed_hold", 32'(bus.cpu_hold), 32'd1);
            check("armed_done", 32'(bus.done), 32'd0);
            check("armed_err",  32'(bus.err), 32'd0);
            for (int w = 0; w < v.nw; w++) push_word(w, v.words[32*w +: 32]);
            for (int i = 0; i < v.nb; i++) send_byte(v.bytes[8*i +: 8], 1'b0);
            wait_idle(50);
            check("vec_done", 32'(bus.done), 32'(v.exp_done));
            check("vec_err",  32'(bus.err), 32'(!v.exp_done));
            check("vec_hold", 32'(bus.cpu_hold), 32'(!v.exp_done));
            check("vec_wc",   32'(bus.word_count), 32'(v.nw));
            check("vec_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        // Sub-half-bit glitch inside the frame must not produce a byte.
        pulse_start();
        send_byte(8'hA5, 1'b0);
        @(negedge clk) bus.rx = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        push_word(0, 32'hDEADBEEF);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h38, 1'b0);
        wait_idle(50);
        check("glitch_done", 32'(bus.done), 32'd1);
        check("glitch_wc",   32'(bus.word_count), 32'd1);
        check("glitch_queue_empty", 32'(exp_q.size()), 32'd0);

        // Bad stop bit on the second data byte.
        pulse_start();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b1);
        repeat (4) @(negedge clk);
        check("frame_err",  32'(bus.err), 32'd1);
        check("frame_busy", 32'(bus.busy), 32'd0);
        check("frame_done", 32'(bus.done), 32'd0);
        check("frame_hold", 32'(bus.cpu_hold), 32'd1);
        check("frame_queue_empty", 32'(exp_q.size()), 32'd0);

        // Idle line mid-frame: still loading just under the limit, error just past it.
        pulse_start();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'hEF, 1'b0);
        repeat ((TO_BITS - 2) * CPB) @(negedge clk);
        check("pre_timeout_busy", 32'(bus.busy), 32'd1);
        check("pre_timeout_err",  32'(bus.err), 32'd0);
        repeat (3 * CPB) @(negedge clk);
        check("timeout_err",  32'(bus.err), 32'd1);
        check("timeout_busy", 32'(bus.busy), 32'd0);
        check("timeout_hold", 32'(bus.cpu_hold), 32'd1);

        // A second start during a load is ignored.
        pulse_start();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h00, 1'b0);
        pulse_start();
        push_word(0, 32'hDEADBEEF);
        send_byte(8'hEF, 1'b0);
        send_byte(8'hBE, 1'b0);
        send_byte(8'hAD, 1'b0);
        send_byte(8'hDE, 1'b0);
        send_byte(8'h38, 1'b0);
        wait_idle(50);
        check("restart_done", 32'(bus.done), 32'd1);
        check("restart_wc",   32'(bus.word_count), 32'd1);
        check("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in DATA clears every output before the next clock edge.
        pulse_start();
        push_word(0, 32'h00000013);
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("pre_rst_wc", 32'(bus.word_count), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        check("rst_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_busy", 32'(bus.busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
